// File: rtl/sat_out_serializer.sv
// sat_out_serializer: captures four parallel saturated vectors into a frame buffer
// and streams them out as 2*DEPTH complex samples with a per-frame clip count.
module sat_out_serializer #(
    parameter int DEPTH       = 16,
    parameter int DOUT_WIDTH  = 13,
    parameter int SAT_MAX_VAL = 4095,
    parameter int SAT_MIN_VAL = -4096
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DOUT_WIDTH-1:0]         din_R_add [DEPTH],
    input  logic signed [DOUT_WIDTH-1:0]         din_R_sub [DEPTH],
    input  logic signed [DOUT_WIDTH-1:0]         din_Q_add [DEPTH],
    input  logic signed [DOUT_WIDTH-1:0]         din_Q_sub [DEPTH],
    output logic                                 dout_valid,
    input  logic                                 dout_ready,
    output logic signed [DOUT_WIDTH-1:0]         dout_re,
    output logic signed [DOUT_WIDTH-1:0]         dout_im,
    output logic [$clog2(2*DEPTH)-1:0]           dout_idx,
    output logic                                 dout_last,
    output logic [$clog2(2*DEPTH+1)-1:0]         dout_clip_cnt
);
    localparam int IW = $clog2(2*DEPTH);
    localparam int CW = $clog2(2*DEPTH+1);
    localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [DOUT_WIDTH-1:0] SMAX = DOUT_WIDTH'(SAT_MAX_VAL);
    localparam logic signed [DOUT_WIDTH-1:0] SMIN = DOUT_WIDTH'(SAT_MIN_VAL);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state;

    logic signed [DOUT_WIDTH-1:0] buf_ra [DEPTH];
    logic signed [DOUT_WIDTH-1:0] buf_rs [DEPTH];
    logic signed [DOUT_WIDTH-1:0] buf_qa [DEPTH];
    logic signed [DOUT_WIDTH-1:0] buf_qs [DEPTH];
    logic capture, fire, load, hi, nclip;
    logic [IW-1:0] nidx;
    logic [LW-1:0] lane;
    logic signed [DOUT_WIDTH-1:0] nre, nim;

    assign fire     = dout_valid && dout_ready;
    assign in_ready = rst_n && (state == IDLE || (fire && dout_last));
    assign capture  = in_valid && in_ready;
    assign load     = capture || (fire && !dout_last);

    // A fresh capture always starts at idx 0, read straight from the inputs
    // since the buffer is being written on the same edge.
    always_comb begin
        nidx  = capture ? '0 : dout_idx + IW'(1);
        hi    = nidx >= IW'(DEPTH);
        lane  = LW'(hi ? nidx - IW'(DEPTH) : nidx);
        nre   = capture ? din_R_add[0] : (hi ? buf_rs[lane] : buf_ra[lane]);
        nim   = capture ? din_Q_add[0] : (hi ? buf_qs[lane] : buf_qa[lane]);
        nclip = nre == SMAX || nre == SMIN || nim == SMAX || nim == SMIN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            dout_valid    <= 1'b0;
            dout_re       <= '0;
            dout_im       <= '0;
            dout_idx      <= '0;
            dout_last     <= 1'b0;
            dout_clip_cnt <= '0;
        end else begin
            if (capture) begin
                buf_ra <= din_R_add;
                buf_rs <= din_R_sub;
                buf_qa <= din_Q_add;
                buf_qs <= din_Q_sub;
            end
            if (load) begin
                state         <= SEND;
                dout_valid    <= 1'b1;
                dout_re       <= nre;
                dout_im       <= nim;
                dout_idx      <= nidx;
                dout_last     <= nidx == IW'(2*DEPTH-1);
                dout_clip_cnt <= (capture ? '0 : dout_clip_cnt) + CW'(nclip);
            end else if (fire) begin
                state      <= IDLE;
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sat_out_serializer.sv
// tb_sat_out_serializer: directed scenario tests for sat_out_serializer.
module tb_sat_out_serializer;
    localparam int D = 16;
    localparam int W = 13;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, dout_ready = 1'b0;
    logic signed [W-1:0] d_ra [D], d_qa [D], d_rs [D], d_qs [D];
    logic in_ready, dout_valid, dout_last;
    logic signed [W-1:0] dout_re, dout_im;
    logic [4:0] dout_idx;
    logic [5:0] dout_clip_cnt;
    int n_tests = 0, n_fail = 0;
    logic signed [W-1:0] m_ra [2][D], m_qa [2][D], m_rs [2][D], m_qs [2][D];

    sat_out_serializer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din_R_add(d_ra), .din_R_sub(d_rs), .din_Q_add(d_qa), .din_Q_sub(d_qs),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_re(dout_re),
        .dout_im(dout_im), .dout_idx(dout_idx), .dout_last(dout_last),
        .dout_clip_cnt(dout_clip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] er(int f, int i);
        if (i < D) return m_ra[f][i];
        return m_rs[f][i-D];
    endfunction

    function automatic logic signed [W-1:0] ei(int f, int i);
        if (i < D) return m_qa[f][i];
        return m_qs[f][i-D];
    endfunction

    function automatic int clipped(int f, int i);
        return (er(f, i) == 4095 || er(f, i) == -4096 || ei(f, i) == 4095 || ei(f, i) == -4096) ? 1 : 0;
    endfunction

    task automatic fill(int f, int kind);
        for (int k = 0; k < D; k++) begin
            case (kind)
                0: begin m_ra[f][k] = W'(k); m_qa[f][k] = W'(-k); m_rs[f][k] = W'(100+k); m_qs[f][k] = W'(-100-k); end
                1: begin m_ra[f][k] = '0; m_qa[f][k] = '0; m_rs[f][k] = '0; m_qs[f][k] = '0; end
                2: begin m_ra[f][k] = W'(3*k+1); m_qa[f][k] = W'(-5*k-7); m_rs[f][k] = W'(200-k); m_qs[f][k] = W'(k*k); end
                default: begin m_ra[f][k] = W'(k-50); m_qa[f][k] = W'(60+k); m_rs[f][k] = W'(-7*k); m_qs[f][k] = W'(300+k); end
            endcase
        end
        if (kind == 1) begin
            m_ra[f][0] = 13'sd4095; m_qa[f][0] = -13'sd4096; m_rs[f][3] = -13'sd4096; m_qs[f][15] = 13'sd4095;
        end
        if (kind == 2) begin
            m_qa[f][2] = 13'sd4095; m_rs[f][15] = 13'sd4095; m_qs[f][15] = -13'sd4096;
        end
    endtask

    task automatic drive(int f);
        for (int k = 0; k < D; k++) begin
            d_ra[k] = m_ra[f][k]; d_qa[k] = m_qa[f][k]; d_rs[k] = m_rs[f][k]; d_qs[k] = m_qs[f][k];
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < D; k++) begin
            d_ra[k] = W'(999-k); d_qa[k] = W'(-999+k); d_rs[k] = W'(777); d_qs[k] = W'(4095);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; dout_ready = 0; scramble();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({dout_valid, dout_re, dout_im, dout_idx, dout_last, dout_clip_cnt, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b re=%0d im=%0d idx=%0d last=%b cnt=%0d in_ready=%b, expected all 0",
                     dout_valid, dout_re, dout_im, dout_idx, dout_last, dout_clip_cnt, in_ready);
        end
        rst_n = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b valid=%b, expected 1 0", in_ready, dout_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: valid=%b, expected 0", dout_valid);
        end
    endtask

    task automatic test_ramp();
        int cnt = 0;
        fill(0, 0); drive(0); dout_ready = 1; in_valid = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0; scramble();
        for (int i = 0; i < 32; i++) begin
            #1;
            cnt += clipped(0, i);
            n_tests++;
            if (dout_valid !== 1'b1 || dout_idx !== 5'(i) || dout_re !== er(0, i) || dout_im !== ei(0, i) ||
                dout_last !== (i == 31) || (i == 31 && dout_clip_cnt !== 6'(cnt))) begin
                n_fail++;
                $display("FAIL ramp_beat %0d: valid=%b idx=%0d re=%0d im=%0d last=%b cnt=%0d, expected re=%0d im=%0d cnt=%0d",
                         i, dout_valid, dout_idx, dout_re, dout_im, dout_last, dout_clip_cnt, er(0, i), ei(0, i), cnt);
            end
            @(posedge clk); #1;
        end
        #1;
        n_tests++;
        if (dout_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_end: valid=%b in_ready=%b, expected 0 1", dout_valid, in_ready);
        end
    endtask

    task automatic test_clip();
        fill(0, 1); drive(0); dout_ready = 1; in_valid = 1;
        #1;
        @(posedge clk); #1;
        in_valid = 0; scramble();
        for (int i = 0; i < 32; i++) begin
            #1;
            n_tests++;
            if (dout_valid !== 1'b1 || dout_idx !== 5'(i) || dout_re !== er(0, i) || dout_im !== ei(0, i) ||
                dout_last !== (i == 31) || (i == 31 && dout_clip_cnt !== 6'd3)) begin
                n_fail++;
                $display("FAIL clip_beat %0d: valid=%b idx=%0d re=%0d im=%0d last=%b cnt=%0d, expected re=%0d im=%0d cnt=3",
                         i, dout_valid, dout_idx, dout_re, dout_im, dout_last, dout_clip_cnt, er(0, i), ei(0, i));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int ne = 0, last_cyc = -1;
        logic stalled = 1'b0;
        logic [5:0] prev_cnt = '0;
        fill(0, 2); drive(0); dout_ready = 1; in_valid = 1;
        #1;
        @(posedge clk); #1;
        in_valid = 0; scramble();
        for (int cyc = 0; cyc < 100 && ne < 32; cyc++) begin
            dout_ready = (cyc % 2 == 0);
            #1;
            n_tests++;
            if (dout_valid !== 1'b1 || dout_idx !== 5'(ne) || dout_re !== er(0, ne) || dout_im !== ei(0, ne) ||
                dout_last !== (ne == 31) || (ne == 31 && dout_clip_cnt !== 6'd2) ||
                (stalled && dout_clip_cnt !== prev_cnt)) begin
                n_fail++;
                $display("FAIL bp_cycle %0d: valid=%b idx=%0d re=%0d im=%0d last=%b cnt=%0d, expected idx=%0d re=%0d im=%0d",
                         cyc, dout_valid, dout_idx, dout_re, dout_im, dout_last, dout_clip_cnt, ne, er(0, ne), ei(0, ne));
            end
            stalled  = !dout_ready;
            prev_cnt = dout_clip_cnt;
            if (dout_ready) begin
                if (ne == 31) last_cyc = cyc;
                ne++;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (last_cyc != 62) begin
            n_fail++;
            $display("FAIL bp_span: last beat at cycle %0d, expected 62", last_cyc);
        end
        dout_ready = 1;
    endtask

    task automatic test_back_to_back();
        fill(0, 3); fill(1, 0); drive(0); dout_ready = 1; in_valid = 1;
        #1;
        @(posedge clk); #1;
        drive(1);
        for (int i = 0; i < 64; i++) begin
            if (i == 32) in_valid = 0;
            #1;
            n_tests++;
            if (dout_valid !== 1'b1 || dout_idx !== 5'(i % 32) || dout_re !== er(i / 32, i % 32) ||
                dout_im !== ei(i / 32, i % 32) || dout_last !== (i % 32 == 31) || in_ready !== (i % 32 == 31)) begin
                n_fail++;
                $display("FAIL b2b_beat %0d: valid=%b idx=%0d re=%0d im=%0d last=%b in_ready=%b, expected re=%0d im=%0d",
                         i, dout_valid, dout_idx, dout_re, dout_im, dout_last, in_ready, er(i / 32, i % 32), ei(i / 32, i % 32));
            end
            @(posedge clk); #1;
        end
        #1;
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b, expected 0", dout_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill(0, 3); drive(0); dout_ready = 1; in_valid = 1;
        #1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (dout_idx !== 5'd10 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: idx=%0d valid=%b, expected 10 1", dout_idx, dout_valid);
        end
        rst_n = 0;
        @(posedge clk); #1;
        n_tests++;
        if (dout_valid !== 1'b0 || in_ready !== 1'b0 || dout_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_assert: valid=%b in_ready=%b idx=%0d, expected 0 0 0", dout_valid, in_ready, dout_idx);
        end
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: in_ready=%b valid=%b, expected 1 0", in_ready, dout_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (dout_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_residual %0d: valid=%b, expected 0", c, dout_valid);
            end
        end
        fill(1, 2); drive(1); in_valid = 1;
        #1;
        @(posedge clk); #1;
        in_valid = 0;
        #1;
        n_tests++;
        if (dout_valid !== 1'b1 || dout_idx !== 5'd0 || dout_re !== er(1, 0) || dout_im !== ei(1, 0)) begin
            n_fail++;
            $display("FAIL rst_mid_restart: valid=%b idx=%0d re=%0d im=%0d, expected 1 0 %0d %0d",
                     dout_valid, dout_idx, dout_re, dout_im, er(1, 0), ei(1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sat_out_serializer.md
SAT_OUT_SERIALIZER -- requirements
Module: sat_out_serializer

Interface
REQ-001 Parameter DEPTH, default 16, lanes per input vector; a frame is 2*DEPTH complex samples.
REQ-002 Parameter DOUT_WIDTH, default 13, signed sample width.
REQ-003 Parameter SAT_MAX_VAL, default 4095, upper rail used for clip detection.
REQ-004 Parameter SAT_MIN_VAL, default -4096, lower rail used for clip detection.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  input frame present on din_* arrays.
REQ-008 in_ready  output  1  block accepts a frame this cycle.
REQ-009 din_R_add, din_R_sub, din_Q_add, din_Q_sub  input  DEPTH x DOUT_WIDTH signed  parallel saturated vectors (R = real, Q = imaginary).
REQ-010 dout_valid  output  1  serial sample present.
REQ-011 dout_ready  input  1  downstream accepts the sample.
REQ-012 dout_re, dout_im  output  DOUT_WIDTH signed  serial complex sample.
REQ-013 dout_idx  output  $clog2(2*DEPTH)  sample index within the frame.
REQ-014 dout_last  output  1  high on the final sample of a frame.
REQ-015 dout_clip_cnt  output  $clog2(2*DEPTH+1)  clipped-sample count for the frame; meaningful only when dout_last=1.

Function
REQ-016 The block SHALL capture all four vectors into an internal frame buffer on the cycle in_valid && in_ready.
REQ-017 The FSM SHALL have states IDLE and SEND: IDLE->SEND on capture; SEND->IDLE when the last beat is accepted with no new capture; SEND->SEND when the last beat is accepted together with a new capture.
REQ-018 in_ready SHALL be 1 in IDLE, 1 in SEND only on the cycle dout_valid && dout_ready && dout_last, and 0 otherwise.
REQ-019 Emission order SHALL be idx k = 0..DEPTH-1: re=R_add[k], im=Q_add[k]; then idx DEPTH+k: re=R_sub[k], im=Q_sub[k].
REQ-020 The first sample SHALL appear with dout_valid=1 on the cycle after capture (latency 1).
REQ-021 A beat SHALL transfer when dout_valid && dout_ready; the next index SHALL appear on the following cycle.
REQ-022 While dout_valid && !dout_ready, dout_re, dout_im, dout_idx, dout_last and dout_clip_cnt SHALL hold stable.
REQ-023 dout_last SHALL be 1 iff dout_idx == 2*DEPTH-1.
REQ-024 A sample SHALL count as clipped if re or im equals SAT_MAX_VAL or SAT_MIN_VAL; it counts once even if both are at a rail.
REQ-025 dout_clip_cnt on the last beat SHALL equal the clipped-sample total of that frame, including the last sample; the count SHALL restart at 0 for each frame.
REQ-026 On back-to-back frames (REQ-017 overlap), idx 0 of the new frame SHALL follow the last beat with no bubble and with the new frame's data.
REQ-027 in_valid while in_ready=0 SHALL be ignored; din_* changes after capture SHALL NOT affect the emitted frame.
REQ-028 dout_valid SHALL stay 0 in IDLE.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, dout_valid=0, dout_re=0, dout_im=0, dout_idx=0, dout_last=0, dout_clip_cnt=0, internal counters=0.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after rst_n returns to 1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; no residual beats SHALL be emitted after release.

Verification
REQ-032 Ramp frame: R_add[k]=k, Q_add[k]=-k, R_sub[k]=100+k, Q_sub[k]=-100-k, dout_ready=1 -> 32 beats on consecutive cycles; idx 0 (0,0) one cycle after capture; idx 31 (115,-115), dout_last=1, dout_clip_cnt=0.
REQ-033 Clip frame: R_add[0]=4095, Q_add[0]=-4096, R_sub[3]=-4096, Q_sub[15]=4095, others 0 -> dout_clip_cnt=3 on idx 31.
REQ-034 Backpressure: toggle dout_ready 1/0 every cycle -> each sample appears exactly once, outputs stable while stalled, frame spans 63 cycles.
REQ-035 Back-to-back: in_valid held with two distinct frames, dout_ready=1 -> in_ready pulses on the idx-31 cycle; 64 contiguous beats, no gap.
REQ-036 Reset at idx 10 -> next cycle dout_valid=0, in_ready=0; after release in_ready=1, no beats until a new capture, which starts at idx 0.
